demux_1_2_3_buf: RTL and testbench
==================================

# demux_1_2_3_buf

Buffered 1-to-2 demultiplexer for 3-bit register-address tokens: the steering counterpart of the datapath's 2:1 3-bit select muxes. A single producer presents a token with a destination select. The block queues the token in the selected channel's FIFO, and each channel drains to its own consumer under a valid/ready handshake. It sits between the decode stage and two independent write-back consumers.

## Interface
- `WIDTH`, 3: token width in bits.
- `DEPTH`, 2: entries per channel FIFO; must be a power of two and at least 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `d`  in  WIDTH  input token.
- `s`  in  1  destination select: 0 routes to channel 0, 1 routes to channel 1.
- `in_valid`  in  1  producer has a token on `d`/`s`.
- `in_ready`  out  1  block accepts the token this cycle.
- `y0`, `y1`  out  WIDTH  head token of channel 0 / channel 1.
- `y0_valid`, `y1_valid`  out  1  channel head is valid.
- `y0_ready`, `y1_ready`  in  1  consumer pops the head this cycle.
- `cnt0`, `cnt1`  out  $clog2(DEPTH)+1  channel occupancy.

## Operation
- Accept happens when `in_valid && in_ready`. The token is written to the FIFO selected by `s`. The other FIFO is untouched.
- `in_ready = s ? !full1 : !full0`.
  - `in_ready` depends only on `s` and the registered full flags. There is no combinational path from `y*_ready`.
  - A full channel therefore blocks the input even if that channel pops in the same cycle.
  - A full channel does not block tokens destined for the other channel.
- Pop happens when `yN_valid && yN_ready`. The head advances by one. `yN_ready` while `yN_valid=0` has no effect.
- `yN_valid = (cntN != 0)`. `yN` shows the head entry. `yN` holds its last value when the channel is empty; verification treats it as don't-care then.
- Simultaneous push and pop on the same channel, when not full: `cntN` is unchanged and the pointers both advance.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full is `cnt == DEPTH`; empty is `cnt == 0`.
- Ordering is FIFO within each channel. There is no ordering relation between the two channels.
- Tokens are never dropped or duplicated. An accept with `in_valid=0` never occurs.
- Reset while `rst_n=0`, asynchronous: both FIFOs are flushed.
  - Pointers = 0, `cnt0 = cnt1 = 0`, `y0_valid = y1_valid = 0`, `y0 = y1 = 0`.
  - `in_ready` then follows the empty state, i.e. it is 1 once reset is released.
  - Reset mid-transfer discards all queued tokens with no partial state.

## Timing
- Latency: a token accepted at edge N is visible on `yN`/`yN_valid` after edge N, i.e. in cycle N+1. Minimum latency is one cycle, with no bypass.
- Throughput: one accept per cycle. One pop per channel per cycle; both channels may pop in the same cycle.
- `cntN` updates on the clock edge following the push or pop.
- All outputs are registered or derived from registered state, except `in_ready`, which is a mux of registered flags by `s`.

## Structure
- Shared package `mips_pkg`: `TOKEN_W = 3`, `CHAN_DEPTH = 2`, `CNT_W = $clog2(CHAN_DEPTH)+1`.
- Sub-module `chan_fifo` (WIDTH, DEPTH), instantiated twice.
  - Inputs: `clk`, `rst_n`, `push`, `push_data`, `pop`.
  - Outputs: `head`, `valid`, `full`, `cnt`.
- The top level contains only the push decode (`push0 = acc && !s`, `push1 = acc && s`), the `in_ready` mux, and the port wiring.

## Test plan
- Reset: assert `rst_n=0` mid-stream with 2 tokens queued per channel, then release. Required: `y0_valid = y1_valid = 0`, `cnt0 = cnt1 = 0`, `y0 = y1 = 3'b000`, `in_ready=1`.
- Steering: send `d=3'b101` with `s=0`, then `d=3'b010` with `s=1`, while `y*_ready=0`. Required: `y0 = 3'b101`, `cnt0 = 1`, `y1 = 3'b010`, `cnt1 = 1`, each visible the cycle after its accept.
- Full/backpressure: push 3'b001 and 3'b011 to channel 0 with `y0_ready=0`. Required: `cnt0 = 2` and `in_ready=0` while `s=0`.
  - Switch to `s=1`: required `in_ready=1`, and 3'b111 lands in channel 1.
- Simultaneous push and pop: channel 1 holds 1 entry; push 3'b100 to channel 1 with `y1_ready=1` in the same cycle. Required: `cnt1` stays 1, and the head becomes 3'b100 on the next cycle.
- Wrap-around: stream 3'b000 through 3'b111 into channel 0 with `y0_ready` toggling randomly. Required: the output sequence is exactly 0 through 7 in order, with no loss or duplication, and pointers wrap at least 3 times.
- Full-block with same-cycle pop: channel 0 is full; assert `y0_ready=1` and `in_valid=1` with `s=0`. Required: `in_ready=0` that cycle, the pop occurs, `cnt0 = 1`, and the push is accepted the next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared datapath constants for the register-address token path.
package mips_pkg;

    localparam int TOKEN_W    = 3;
    localparam int CHAN_DEPTH = 2;
    localparam int CNT_W      = $clog2(CHAN_DEPTH) + 1;

endpackage

// File: rtl/chan_fifo.sv
// Single-channel token FIFO with registered occupancy and full flag.
module chan_fifo
    import mips_pkg::*;
#(
    parameter int WIDTH = TOKEN_W,
    parameter int DEPTH = CHAN_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    cnt_next;
    logic             do_push;
    logic             do_pop;

    // A full channel refuses pushes even when it pops in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign valid   = (cnt != '0);
    assign head    = mem[rd_ptr];

    always_comb begin
        cnt_next = cnt;
        case ({do_push, do_pop})
            2'b10:   cnt_next = cnt + CW'(1);
            2'b01:   cnt_next = cnt - CW'(1);
            default: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt  <= cnt_next;
            full <= (cnt_next == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/demux_1_2_3_buf.sv
// Buffered 1-to-2 demux: steers each accepted token into one of two channel FIFOs.
module demux_1_2_3_buf
    import mips_pkg::*;
#(
    parameter int WIDTH = TOKEN_W,
    parameter int DEPTH = CHAN_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           d,
    input  logic                       s,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           y0,
    output logic [WIDTH-1:0]           y1,
    output logic                       y0_valid,
    output logic                       y1_valid,
    input  logic                       y0_ready,
    input  logic                       y1_ready,
    output logic [$clog2(DEPTH):0]     cnt0,
    output logic [$clog2(DEPTH):0]     cnt1
);

    logic full0;
    logic full1;
    logic acc;
    logic push0;
    logic push1;

    // Only registered full flags feed in_ready; no path from the consumer side.
    assign in_ready = s ? !full1 : !full0;
    assign acc      = in_valid && in_ready;
    assign push0    = acc && !s;
    assign push1    = acc && s;

    chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (d),
        .pop       (y0_ready),
        .head      (y0),
        .valid     (y0_valid),
        .full      (full0),
        .cnt       (cnt0)
    );

    chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (d),
        .pop       (y1_ready),
        .head      (y1),
        .valid     (y1_valid),
        .full      (full1),
        .cnt       (cnt1)
    );

endmodule

// File: tb/tb_demux_1_2_3_buf.sv
// Directed-vector bench for the buffered 1-to-2 token demux.
module tb_demux_1_2_3_buf;
    import mips_pkg::*;

    logic                clk;
    logic                rst_n;
    logic [TOKEN_W-1:0]  d;
    logic                s;
    logic                in_valid;
    logic                in_ready;
    logic [TOKEN_W-1:0]  y0;
    logic [TOKEN_W-1:0]  y1;
    logic                y0_valid;
    logic                y1_valid;
    logic                y0_ready;
    logic                y1_ready;
    logic [CNT_W-1:0]    cnt0;
    logic [CNT_W-1:0]    cnt1;

    int checks;
    int errors;

    demux_1_2_3_buf #(.WIDTH(TOKEN_W), .DEPTH(CHAN_DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .s        (s),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y0       (y0),
        .y1       (y1),
        .y0_valid (y0_valid),
        .y1_valid (y1_valid),
        .y0_ready (y0_ready),
        .y1_ready (y1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic       sel;
        logic [2:0] din;
        logic       r0;
        logic       r1;
        logic       ir;
        logic [1:0] c0;
        logic [1:0] c1;
        logic [2:0] h0;
        logic [2:0] h1;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_state(input string tag);
        chk({tag, " y0_valid"}, int'(y0_valid), 0);
        chk({tag, " y1_valid"}, int'(y1_valid), 0);
        chk({tag, " cnt0"}, int'(cnt0), 0);
        chk({tag, " cnt1"}, int'(cnt1), 0);
        chk({tag, " y0"}, int'(y0), 0);
        chk({tag, " y1"}, int'(y1), 0);
        chk({tag, " in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        int sent;
        int rx;
        int cyc;
        logic acc;
        logic popped;

        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        d        = '0;
        s        = 1'b0;
        in_valid = 1'b0;
        y0_ready = 1'b0;
        y1_ready = 1'b0;

        //         iv  s  d      r0 r1 ir c0 c1 h0     h1
        vecs[0]  = '{1, 0, 3'b101, 0, 0, 1, 1, 0, 3'b101, 3'b000};
        vecs[1]  = '{1, 1, 3'b010, 0, 0, 1, 1, 1, 3'b101, 3'b010};
        vecs[2]  = '{0, 0, 3'b000, 1, 0, 1, 0, 1, 3'b000, 3'b010};
        vecs[3]  = '{1, 0, 3'b001, 0, 0, 1, 1, 1, 3'b001, 3'b010};
        vecs[4]  = '{1, 0, 3'b011, 0, 0, 1, 2, 1, 3'b001, 3'b010};
        vecs[5]  = '{1, 0, 3'b110, 0, 0, 0, 2, 1, 3'b001, 3'b010};
        vecs[6]  = '{1, 1, 3'b111, 0, 0, 1, 2, 2, 3'b001, 3'b010};
        vecs[7]  = '{0, 1, 3'b000, 0, 1, 0, 2, 1, 3'b001, 3'b111};
        vecs[8]  = '{1, 1, 3'b100, 0, 1, 1, 2, 1, 3'b001, 3'b100};
        vecs[9]  = '{1, 0, 3'b101, 1, 0, 0, 1, 1, 3'b011, 3'b100};
        vecs[10] = '{1, 0, 3'b101, 0, 0, 1, 2, 1, 3'b011, 3'b100};
        vecs[11] = '{0, 1, 3'b000, 0, 1, 1, 2, 0, 3'b011, 3'b000};
        vecs[12] = '{0, 1, 3'b000, 0, 1, 1, 2, 0, 3'b011, 3'b000};
        vecs[13] = '{1, 1, 3'b011, 0, 0, 1, 2, 1, 3'b011, 3'b011};
        vecs[14] = '{1, 1, 3'b110, 0, 0, 1, 2, 2, 3'b011, 3'b011};
        vecs[15] = '{0, 0, 3'b000, 0, 0, 0, 2, 2, 3'b011, 3'b011};

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk_idle_state("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven steering, backpressure, same-cycle push/pop, full-block
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = vecs[i].iv;
            s        = vecs[i].sel;
            d        = vecs[i].din;
            y0_ready = vecs[i].r0;
            y1_ready = vecs[i].r1;
            #1;
            chk($sformatf("v%0d in_ready", i), int'(in_ready), int'(vecs[i].ir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d cnt0", i), int'(cnt0), int'(vecs[i].c0));
            chk($sformatf("v%0d cnt1", i), int'(cnt1), int'(vecs[i].c1));
            chk($sformatf("v%0d y0_valid", i), int'(y0_valid), int'(vecs[i].c0 != 0));
            chk($sformatf("v%0d y1_valid", i), int'(y1_valid), int'(vecs[i].c1 != 0));
            if (vecs[i].c0 != 0) chk($sformatf("v%0d y0", i), int'(y0), int'(vecs[i].h0));
            if (vecs[i].c1 != 0) chk($sformatf("v%0d y1", i), int'(y1), int'(vecs[i].h1));
        end

        // Asynchronous reset mid-stream with both channels full
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_state("async rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle_state("post rst");

        // Stream 0..7 through channel 0 with random consumer backpressure
        sent = 0;
        rx   = 0;
        cyc  = 0;
        while ((rx < 8) && (cyc < 300)) begin
            @(negedge clk);
            in_valid = (sent < 8);
            s        = 1'b0;
            d        = 3'(sent);
            y0_ready = 1'($urandom_range(0, 1));
            y1_ready = 1'b0;
            #1;
            acc    = in_valid && in_ready;
            popped = y0_valid && y0_ready;
            if (popped) chk($sformatf("stream token %0d", rx), int'(y0), rx);
            @(posedge clk);
            if (acc) sent++;
            if (popped) rx++;
            cyc++;
        end
        chk("stream tokens received", rx, 8);
        chk("stream tokens sent", sent, 8);
        @(negedge clk);
        in_valid = 1'b0;
        y0_ready = 1'b0;
        #1;
        chk("stream drained cnt0", int'(cnt0), 0);
        chk("stream cnt1 untouched", int'(cnt1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
